// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a small transmit FIFO.
//
// Two registers are visible to the core:
//   BASE_ADDR    IO  : write pushes a character; read returns the last accepted one
//   BASE_ADDR+1  CSR : [0] busy, [1] full, [2] empty, [3] overflow (sticky,
//                      write 1 to clear), [8:4] FIFO count
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous reset, active low
//   io_addr         register address
//   io_wdata        write data (low DATA_W bits for IO, bit 3 for CSR)
//   io_we           write strobe
//   io_rdata        combinational read data for io_addr
//   io_uart_io_reg  mirror of the IO register
//   io_uart_csr_reg mirror of the CSR register
//   tx              registered serial line, idles high (8N1-style framing)
module mmio_uart_tx #(
  parameter int         DATA_W       = 8,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         CLKS_PER_BIT = 4,
  parameter logic [7:0] BASE_ADDR    = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_we,
  output logic [31:0] io_rdata,
  output logic [31:0] io_uart_io_reg,
  output logic [31:0] io_uart_csr_reg,
  output logic        tx
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [7:0]       CSR_ADDR = BASE_ADDR + 8'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and control
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [DATA_W-1:0] last_byte;

  // Serializer
  state_t            state;
  logic [CLK_W-1:0]  clk_cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              line;

  logic io_sel, csr_sel, full, empty, busy, pop, push, ovf_set, ovf_clr;

  // Only the character bits and CSR bit 3 carry meaning; the rest are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^io_wdata;

  assign io_sel  = io_we && (io_addr == BASE_ADDR);
  assign csr_sel = io_we && (io_addr == CSR_ADDR);
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);

  // The head is taken either from idle or on the last cycle of a stop bit,
  // which is what makes consecutive frames run back to back.
  assign pop = !empty &&
               ((state == IDLE) || ((state == STOP) && (clk_cnt == CLK_LAST)));

  // A simultaneous pop frees the slot, so a write to a full FIFO is still
  // accepted on that edge.
  assign push    = io_sel && (!full || pop);
  assign ovf_set = io_sel && full && !pop;
  assign ovf_clr = csr_sel && io_wdata[3];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= io_wdata[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      last_byte <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + PTR_W'(1);
        last_byte <= io_wdata[DATA_W-1:0];
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Clear wins if both ever coincide.
      if (ovf_clr)      overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
    end
  end

  // Line level implied by the current state; registered into tx, so the
  // serial output trails the state by one cycle.
  always_comb begin
    line = 1'b1;
    case (state)
      START:   line = 1'b0;
      DATA:    line = shreg[0];
      default: line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      tx <= line;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (pop) begin
            state <= START;
            shreg <= mem[rd_ptr];
          end
        end
        START: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        DATA: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + BIT_W'(1);
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              state   <= STOP;
            end
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        STOP: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            if (pop) begin
              state <= START;
              shreg <= mem[rd_ptr];
            end else begin
              state <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CLK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_uart_io_reg  = {{(32-DATA_W){1'b0}}, last_byte};
  assign io_uart_csr_reg = {23'd0, 5'(count), overflow, empty, full, busy};

  always_comb begin
    io_rdata = 32'd0;
    if (io_addr == BASE_ADDR)     io_rdata = io_uart_io_reg;
    else if (io_addr == CSR_ADDR) io_rdata = io_uart_csr_reg;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx (DATA_W=8, FIFO_DEPTH=4,
// CLKS_PER_BIT=4, BASE_ADDR=0). Outputs are sampled 1 time unit after
// each rising edge.
module tb_mmio_uart_tx;

  logic        clk;
  logic        rst;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic [31:0] io_rdata;
  logic [31:0] io_uart_io_reg;
  logic [31:0] io_uart_csr_reg;
  logic        tx;

  int tests  = 0;
  int failed = 0;

  mmio_uart_tx #(
    .DATA_W      (8),
    .FIFO_DEPTH  (4),
    .CLKS_PER_BIT(4),
    .BASE_ADDR   (8'h00)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .io_addr        (io_addr),
    .io_wdata       (io_wdata),
    .io_we          (io_we),
    .io_rdata       (io_rdata),
    .io_uart_io_reg (io_uart_io_reg),
    .io_uart_csr_reg(io_uart_csr_reg),
    .tx             (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected tx waveform of one frame, one entry per clock: start, 8 data
  // bits LSB first, stop, each held 4 cycles.
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [9:0]  f;
    logic [39:0] r;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) r[i] = f[i/4];
    return r;
  endfunction

  logic [39:0]  txv40;
  logic [199:0] txv200;
  logic [199:0] exp200;
  int           busy_cnt;
  int           low_cnt;

  initial begin
    rst      = 1'b0;
    io_we    = 1'b0;
    io_addr  = 8'h00;
    io_wdata = 32'd0;
    repeat (3) tick();

    // Reset state
    check("rst_tx", tx, 1);
    check("rst_csr_mirror", io_uart_csr_reg, 32'h4);
    check("rst_io_mirror", io_uart_io_reg, 32'h0);
    io_addr = 8'h01; #1;
    check("rst_rd_csr", io_rdata, 32'h4);
    io_addr = 8'h00; #1;
    check("rst_rd_io", io_rdata, 32'h0);
    rst = 1'b1;
    tick();

    // Single frame 0x55; upper write bits must be ignored
    io_addr = 8'h00; io_wdata = 32'hABCD_0055; io_we = 1'b1;
    tick();
    io_we = 1'b0;
    check("single_io_reg", io_uart_io_reg, 32'h55);
    check("single_csr_queued", io_uart_csr_reg, 32'h010);
    check("single_tx_idle_n", tx, 1);
    busy_cnt = 0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 1) begin
        check("single_tx_n1", tx, 1);
        check("single_csr_n1", io_uart_csr_reg, 32'h005);
      end
      if (i >= 2 && i <= 41) txv40[i-2] = tx;
      if (io_uart_csr_reg[0]) busy_cnt++;
    end
    check("single_frame", txv40, frame_bits(8'h55));
    check("single_busy_cycles", busy_cnt, 40);
    check("single_csr_done", io_uart_csr_reg, 32'h004);

    // Six back-to-back writes: five accepted, the sixth overflows
    for (int k = 0; k < 6; k++) begin
      io_addr = 8'h00; io_wdata = 32'(k + 1); io_we = 1'b1;
      tick();
      if (k >= 2) txv200[k-2] = tx;
    end
    io_we = 1'b0;
    check("burst_io_reg", io_uart_io_reg, 32'h05);
    check("burst_csr_ovf", io_uart_csr_reg, 32'h04B);
    // Clear overflow; other status bits stay as they were
    io_addr = 8'h01; io_wdata = 32'h8; io_we = 1'b1;
    tick();
    txv200[4] = tx;
    io_we = 1'b0;
    check("clear_csr", io_uart_csr_reg, 32'h043);
    check("clear_rd_csr", io_rdata, 32'h043);
    for (int j = 5; j < 200; j++) begin
      tick();
      txv200[j] = tx;
    end
    for (int b = 0; b < 5; b++) exp200[b*40 +: 40] = frame_bits(8'(b + 1));
    check("burst_frames", txv200, exp200);
    check("burst_csr_done", io_uart_csr_reg, 32'h004);

    // Write on the exact edge where a full FIFO pops at stop end
    for (int k = 0; k < 5; k++) begin
      io_addr = 8'h00; io_wdata = 32'h10 + 32'(k); io_we = 1'b1;
      tick();
    end
    io_we = 1'b0;
    repeat (36) tick();
    check("popedge_pre_full", io_uart_csr_reg, 32'h043);
    io_addr = 8'h00; io_wdata = 32'h99; io_we = 1'b1;
    tick();
    check("popedge_csr", io_uart_csr_reg, 32'h043);
    check("popedge_io_reg", io_uart_io_reg, 32'h99);
    io_wdata = 32'h77;
    tick();
    check("drop_csr", io_uart_csr_reg, 32'h04B);
    check("drop_io_reg", io_uart_io_reg, 32'h99);
    io_addr = 8'h01; io_wdata = 32'hFFFF_FFF8;
    tick();
    io_we = 1'b0;
    check("clear2_csr", io_uart_csr_reg, 32'h043);
    io_addr = 8'h02; #1;
    check("rd_unmapped", io_rdata, 32'h0);
    repeat (38) tick();
    io_addr = 8'h01; #1;
    check("rd_busy_3q", io_rdata, 32'h031);

    // Reset just as the next frame starts
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_csr", io_uart_csr_reg, 32'h004);
    check("rst_mid_io", io_uart_io_reg, 32'h0);

    // Frame 0xA5 with two entries queued, reset during a low data bit
    io_addr = 8'h00; io_wdata = 32'hA5; io_we = 1'b1;
    tick();
    io_wdata = 32'h11;
    tick();
    io_wdata = 32'h22;
    tick();
    io_we = 1'b0;
    check("a5_csr_2q", io_uart_csr_reg, 32'h021);
    repeat (9) tick();
    check("a5_data_bit1", tx, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("a5_rst_tx", tx, 1);
    check("a5_rst_csr", io_uart_csr_reg, 32'h004);
    io_addr = 8'h01; #1;
    check("a5_rst_rd_csr", io_rdata, 32'h004);
    low_cnt  = 0;
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx == 1'b0) low_cnt++;
      if (io_uart_csr_reg[0]) busy_cnt++;
    end
    check("a5_no_more_tx", low_cnt, 0);
    check("a5_no_more_busy", busy_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
